// File: rtl/per2axi_req_issue.sv
// Issue stage of a peripheral-to-AXI bridge: grants one peripheral request at a time
// and turns it into a single-beat AXI write (AW+W) or read (AR), tracking one busy bit per AXI ID.
module per2axi_req_issue #(
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      per_slave_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_ni,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,

    output logic                      axi_master_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
    input  logic                      axi_master_aw_ready_i,

    output logic                      axi_master_w_valid_o,
    output logic [63:0]               axi_master_w_data_o,
    output logic [7:0]                axi_master_w_strb_o,
    input  logic                      axi_master_w_ready_i,

    output logic                      axi_master_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
    input  logic                      axi_master_ar_ready_i,

    input  logic                      rsp_done_i,
    input  logic [AXI_ID_WIDTH-1:0]   rsp_id_i,

    output logic                      trans_req_o,
    output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o
);

    localparam int NUM_IDS = 2 ** AXI_ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_IDS-1:0]        busy_q, busy_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [63:0]               data_q, data_d;
    logic [7:0]                strb_q, strb_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      ar_valid_q, ar_valid_d;

    logic [AXI_ID_WIDTH-1:0]   req_id;
    logic                      gnt;

    // Lowest set bit wins; descending scan lets the lowest index overwrite the others.
    always_comb begin
        req_id = '0;
        for (int i = PER_ID_WIDTH - 1; i >= 0; i--) begin
            if (per_slave_id_i[i]) begin
                req_id = AXI_ID_WIDTH'(i);
            end
        end
    end

    assign gnt = !rst_i && (state_q == IDLE) && per_slave_req_i && !busy_q[req_id];

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        addr_d     = addr_q;
        id_d       = id_q;
        data_d     = data_q;
        strb_d     = strb_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;

        if (rsp_done_i) begin
            busy_d[rsp_id_i] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (gnt) begin
                    busy_d[req_id] = 1'b1;
                    addr_d         = per_slave_add_i;
                    id_d           = req_id;
                    if (per_slave_add_i[2]) begin
                        data_d = {per_slave_wdata_i, 32'h0};
                        strb_d = {per_slave_be_i, 4'h0};
                    end else begin
                        data_d = {32'h0, per_slave_wdata_i};
                        strb_d = {4'h0, per_slave_be_i};
                    end
                    if (per_slave_we_ni) begin
                        state_d    = READ;
                        ar_valid_d = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; leave only once both have handshaken.
                if (axi_master_aw_ready_i) begin
                    aw_valid_d = 1'b0;
                end
                if (axi_master_w_ready_i) begin
                    w_valid_d = 1'b0;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (axi_master_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            addr_q     <= '0;
            id_q       <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
        end
    end

    assign per_slave_gnt_o       = gnt;

    assign axi_master_aw_valid_o = aw_valid_q;
    assign axi_master_aw_addr_o  = addr_q;
    assign axi_master_aw_id_o    = id_q;

    assign axi_master_w_valid_o  = w_valid_q;
    assign axi_master_w_data_o   = data_q;
    assign axi_master_w_strb_o   = strb_q;

    assign axi_master_ar_valid_o = ar_valid_q;
    assign axi_master_ar_addr_o  = addr_q;
    assign axi_master_ar_id_o    = id_q;

    // Transaction notification is zero outside a grant so it reads as idle during reset.
    assign trans_req_o = gnt;
    assign trans_id_o  = gnt ? req_id : '0;
    assign trans_add_o = gnt ? per_slave_add_i : '0;

endmodule

// File: tb/tb_per2axi_req_issue.sv
// Randomised bench for per2axi_req_issue: a transaction-level model predicts grants and
// outstanding beats, a separate monitor compares DUT outputs against queued expectations.
module tb_per2axi_req_issue;

    localparam int PW = 5;
    localparam int AW = 32;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          per_slave_req_i;
    logic [AW-1:0] per_slave_add_i;
    logic          per_slave_we_ni;
    logic [31:0]   per_slave_wdata_i;
    logic [3:0]    per_slave_be_i;
    logic [PW-1:0] per_slave_id_i;
    logic          per_slave_gnt_o;
    logic          aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [IW-1:0] aw_id, ar_id;
    logic [63:0]   w_data;
    logic [7:0]    w_strb;
    logic          rsp_done_i;
    logic [IW-1:0] rsp_id_i;
    logic          trans_req_o;
    logic [IW-1:0] trans_id_o;
    logic [AW-1:0] trans_add_o;

    per2axi_req_issue #(
        .PER_ID_WIDTH  (PW),
        .AXI_ADDR_WIDTH(AW),
        .AXI_ID_WIDTH  (IW)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .per_slave_req_i      (per_slave_req_i),
        .per_slave_add_i      (per_slave_add_i),
        .per_slave_we_ni      (per_slave_we_ni),
        .per_slave_wdata_i    (per_slave_wdata_i),
        .per_slave_be_i       (per_slave_be_i),
        .per_slave_id_i       (per_slave_id_i),
        .per_slave_gnt_o      (per_slave_gnt_o),
        .axi_master_aw_valid_o(aw_valid),
        .axi_master_aw_addr_o (aw_addr),
        .axi_master_aw_id_o   (aw_id),
        .axi_master_aw_ready_i(aw_ready),
        .axi_master_w_valid_o (w_valid),
        .axi_master_w_data_o  (w_data),
        .axi_master_w_strb_o  (w_strb),
        .axi_master_w_ready_i (w_ready),
        .axi_master_ar_valid_o(ar_valid),
        .axi_master_ar_addr_o (ar_addr),
        .axi_master_ar_id_o   (ar_id),
        .axi_master_ar_ready_i(ar_ready),
        .rsp_done_i           (rsp_done_i),
        .rsp_id_i             (rsp_id_i),
        .trans_req_o          (trans_req_o),
        .trans_id_o           (trans_id_o),
        .trans_add_o          (trans_add_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [63:0]   data;
        logic [7:0]    strb;
    } beat_t;

    beat_t aw_q[$];
    beat_t w_q[$];
    beat_t ar_q[$];
    beat_t trans_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: set of busy IDs plus which beats are outstanding.
    bit            busy_m[8];
    bit            aw_pend = 1'b0;
    bit            w_pend  = 1'b0;
    bit            ar_pend = 1'b0;
    bit            exp_gnt = 1'b0;

    bit            prev_rst = 1'b1;
    bit            prev_gnt = 1'b0;
    bit            prev_we_n = 1'b0;
    logic [IW-1:0] prev_gid = '0;
    bit            prev_aw_rdy = 1'b0;
    bit            prev_w_rdy = 1'b0;
    bit            prev_ar_rdy = 1'b0;
    bit            prev_rsp_done = 1'b0;
    logic [IW-1:0] prev_rsp_id = '0;

    beat_t         mon_b;

    function automatic logic [IW-1:0] lowestId(input logic [PW-1:0] id);
        for (int i = 0; i < PW; i++) begin
            if (id[i]) return IW'(i);
        end
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) busy_m[i] = 1'b0;
        aw_pend = 1'b0;
        w_pend  = 1'b0;
        ar_pend = 1'b0;
        aw_q.delete();
        w_q.delete();
        ar_q.delete();
        trans_q.delete();
    endtask

    task automatic applyStimulus(input bit rst, input bit req, input bit we_n,
                                 input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [PW-1:0] id,
                                 input bit aw_rdy, input bit w_rdy, input bit ar_rdy,
                                 input bit rsp_done, input logic [IW-1:0] rsp_id);
        logic [IW-1:0] gid;
        beat_t         b;
        @(negedge clk_i);
        // Effect of the clock edge that just happened, using last cycle's inputs.
        if (prev_rst) begin
            clearModel();
        end else begin
            if (aw_pend && prev_aw_rdy) aw_pend = 1'b0;
            if (w_pend && prev_w_rdy) w_pend = 1'b0;
            if (ar_pend && prev_ar_rdy) ar_pend = 1'b0;
            if (prev_rsp_done) busy_m[prev_rsp_id] = 1'b0;
            if (prev_gnt) begin
                busy_m[prev_gid] = 1'b1;
                if (prev_we_n) begin
                    ar_pend = 1'b1;
                end else begin
                    aw_pend = 1'b1;
                    w_pend  = 1'b1;
                end
            end
        end

        rst_i             = rst;
        per_slave_req_i   = req;
        per_slave_we_ni   = we_n;
        per_slave_add_i   = addr;
        per_slave_wdata_i = wdata;
        per_slave_be_i    = be;
        per_slave_id_i    = id;
        aw_ready          = aw_rdy;
        w_ready           = w_rdy;
        ar_ready          = ar_rdy;
        rsp_done_i        = rsp_done;
        rsp_id_i          = rsp_id;

        gid = lowestId(id);
        if (rst) begin
            clearModel();
            exp_gnt = 1'b0;
        end else begin
            exp_gnt = req && !aw_pend && !w_pend && !ar_pend && !busy_m[gid];
        end

        if (exp_gnt) begin
            b.addr = addr;
            b.id   = gid;
            b.data = addr[2] ? {wdata, 32'h0} : {32'h0, wdata};
            b.strb = addr[2] ? {be, 4'h0} : {4'h0, be};
            trans_q.push_back(b);
            if (we_n) begin
                ar_q.push_back(b);
            end else begin
                aw_q.push_back(b);
                w_q.push_back(b);
            end
        end

        prev_rst      = rst;
        prev_gnt      = exp_gnt;
        prev_we_n     = we_n;
        prev_gid      = gid;
        prev_aw_rdy   = aw_rdy;
        prev_w_rdy    = w_rdy;
        prev_ar_rdy   = ar_rdy;
        prev_rsp_done = rsp_done;
        prev_rsp_id   = rsp_id;
    endtask

    task automatic idleCycle(input bit rdy, input bit rsp_done, input logic [IW-1:0] rsp_id);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rdy, rdy, rdy, rsp_done, rsp_id);
    endtask

    // Monitor: samples mid-cycle, pops expected beats on every DUT handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            checkOutput("gnt", 64'(per_slave_gnt_o), 64'(exp_gnt));
            checkOutput("trans_req", 64'(trans_req_o), 64'(exp_gnt));
            if (trans_req_o) begin
                checkOutput("trans_expected", 64'(trans_q.size() != 0), 64'(1));
                if (trans_q.size() != 0) begin
                    mon_b = trans_q.pop_front();
                    checkOutput("trans_id", 64'(trans_id_o), 64'(mon_b.id));
                    checkOutput("trans_add", 64'(trans_add_o), 64'(mon_b.addr));
                end
            end
            checkOutput("aw_valid", 64'(aw_valid), 64'(aw_pend));
            checkOutput("w_valid", 64'(w_valid), 64'(w_pend));
            checkOutput("ar_valid", 64'(ar_valid), 64'(ar_pend));
            if (aw_valid && aw_ready && aw_q.size() != 0) begin
                mon_b = aw_q.pop_front();
                checkOutput("aw_addr", 64'(aw_addr), 64'(mon_b.addr));
                checkOutput("aw_id", 64'(aw_id), 64'(mon_b.id));
            end
            if (w_valid && w_ready && w_q.size() != 0) begin
                mon_b = w_q.pop_front();
                checkOutput("w_data", w_data, mon_b.data);
                checkOutput("w_strb", 64'(w_strb), 64'(mon_b.strb));
            end
            if (ar_valid && ar_ready && ar_q.size() != 0) begin
                mon_b = ar_q.pop_front();
                checkOutput("ar_addr", 64'(ar_addr), 64'(mon_b.addr));
                checkOutput("ar_id", 64'(ar_id), 64'(mon_b.id));
            end
            if (rst_i) begin
                checkOutput("reset_outputs_zero",
                            64'(|{per_slave_gnt_o, aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb,
                                  ar_valid, ar_addr, ar_id, trans_req_o, trans_id_o, trans_add_o}),
                            64'(0));
            end
        end
    end

    initial begin
        logic [PW-1:0] rid;
        rst_i = 1'b1;
        per_slave_req_i = 1'b0;
        per_slave_add_i = '0;
        per_slave_we_ni = 1'b0;
        per_slave_wdata_i = '0;
        per_slave_be_i = '0;
        per_slave_id_i = '0;
        aw_ready = 1'b0;
        w_ready = 1'b0;
        ar_ready = 1'b0;
        rsp_done_i = 1'b0;
        rsp_id_i = '0;

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 5'b00001, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Write to upper lane, all readies high: grant, single handshake cycle, idle.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);

        // Read with AR back-pressure for three cycles.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'hF, 5'b00001, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) idleCycle(1'b0, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);

        // ID 2 still busy: held off until its response retires.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h0, 4'hF, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h0, 4'hF, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h0, 4'hF, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h0, 4'hF, 5'b00100, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        idleCycle(1'b1, 1'b1, 3'd2);
        idleCycle(1'b1, 1'b0, 3'd0);

        // AW accepted at once, W only two cycles later; lower lane with sparse strobes.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h1234_5678, 4'b0101, 5'b01000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);

        // Reset while W is still outstanding, then reuse the same ID.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000_000C, 32'hCAFE_F00D, 4'hC, 5'b10000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000_0008, 32'hA5A5_5A5A, 4'h3, 5'b10000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);
        idleCycle(1'b1, 1'b0, 3'd0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) rid = PW'($urandom);
            else rid = PW'(1 << $urandom_range(0, PW - 1));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          AW'($urandom), 32'($urandom), 4'($urandom), rid,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) == 0, IW'($urandom_range(0, PW - 1)));
        end

        for (int i = 0; i < 4; i++) idleCycle(1'b1, 1'b0, 3'd0);
        #4;
        checkOutput("aw_queue_drained", 64'(aw_q.size()), 64'(0));
        checkOutput("w_queue_drained", 64'(w_q.size()), 64'(0));
        checkOutput("ar_queue_drained", 64'(ar_q.size()), 64'(0));
        checkOutput("trans_queue_drained", 64'(trans_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/per2axi_req_issue.md
PER2AXI_REQ_ISSUE -- requirements
Module: per2axi_req_issue

Interface
REQ-001 SHALL have parameter PER_ID_WIDTH, default 5, meaning number of one-hot peripheral ID bits.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AXI and peripheral address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 3, meaning AXI ID width; it SHALL satisfy 2**AXI_ID_WIDTH >= PER_ID_WIDTH.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port per_slave_req_i, input, 1, peripheral request valid.
REQ-007 SHALL have port per_slave_add_i, input, AXI_ADDR_WIDTH, request byte address.
REQ-008 SHALL have port per_slave_we_ni, input, 1, 0=write, 1=read.
REQ-009 SHALL have port per_slave_wdata_i, input, 32, write data.
REQ-010 SHALL have port per_slave_be_i, input, 4, byte enables.
REQ-011 SHALL have port per_slave_id_i, input, PER_ID_WIDTH, one-hot requester ID.
REQ-012 SHALL have port per_slave_gnt_o, output, 1, request grant.
REQ-013 SHALL have port axi_master_aw_valid_o, output, 1, AW valid.
REQ-014 SHALL have port axi_master_aw_addr_o, output, AXI_ADDR_WIDTH, AW address.
REQ-015 SHALL have port axi_master_aw_id_o, output, AXI_ID_WIDTH, AW ID.
REQ-016 SHALL have port axi_master_aw_ready_i, input, 1, AW ready.
REQ-017 SHALL have port axi_master_w_valid_o, output, 1, W valid.
REQ-018 SHALL have port axi_master_w_data_o, output, 64, W data.
REQ-019 SHALL have port axi_master_w_strb_o, output, 8, W strobes.
REQ-020 SHALL have port axi_master_w_ready_i, input, 1, W ready.
REQ-021 SHALL have port axi_master_ar_valid_o, output, 1, AR valid.
REQ-022 SHALL have port axi_master_ar_addr_o, output, AXI_ADDR_WIDTH, AR address.
REQ-023 SHALL have port axi_master_ar_id_o, output, AXI_ID_WIDTH, AR ID.
REQ-024 SHALL have port axi_master_ar_ready_i, input, 1, AR ready.
REQ-025 SHALL have port rsp_done_i, input, 1, R or B handshake completed downstream.
REQ-026 SHALL have port rsp_id_i, input, AXI_ID_WIDTH, ID of the completed response.
REQ-027 SHALL have port trans_req_o, output, 1, one-cycle pulse on accepted request.
REQ-028 SHALL have port trans_id_o, output, AXI_ID_WIDTH, AXI ID of the accepted request.
REQ-029 SHALL have port trans_add_o, output, AXI_ADDR_WIDTH, address of the accepted request.

Function
REQ-030 SHALL use FSM states IDLE, WRITE and READ; grant SHALL be possible only in IDLE.
REQ-031 SHALL map per_slave_id_i to an AXI ID equal to the index of its lowest set bit; an all-zero ID SHALL map to 0.
REQ-032 SHALL keep one busy bit per AXI ID; per_slave_gnt_o SHALL be combinational and equal 1 iff state==IDLE, per_slave_req_i==1 and the registered busy bit of the mapped ID is 0.
REQ-033 On grant SHALL: set busy[id]; register address, ID, data and strobes; drive trans_req_o=1 with trans_id_o/trans_add_o in the same cycle; move to WRITE (we_ni=0) or READ (we_ni=1).
REQ-034 In WRITE, aw_valid and w_valid SHALL rise together one cycle after grant; each SHALL drop independently after its own valid&ready cycle; FSM SHALL return to IDLE in the cycle after both handshakes complete, including the case where both complete in the same cycle.
REQ-035 W lane placement: add[2]==0 -> data[31:0]=wdata, strb=8'h0F masked by be; add[2]==1 -> data[63:32]=wdata, strb={be,4'h0}; unused lanes SHALL be 0.
REQ-036 In READ, ar_valid SHALL rise one cycle after grant and drop after ar_valid&ar_ready; FSM then SHALL return to IDLE.
REQ-037 Valids SHALL remain asserted and AW, W and AR payloads stable until handshake, regardless of ready.
REQ-038 rsp_done_i SHALL clear busy[rsp_id_i] at the next clock edge; a clear and a grant on the same ID in the same cycle cannot occur (the grant sees busy=1); a clear on a non-busy ID SHALL be ignored.
REQ-039 Fixed beat format (len=0, size=2, INCR, last=1) SHALL be tied by the parent; the block issues single 32-bit beats only.
REQ-040 Minimum issue spacing SHALL be 2 cycles (grant, handshake with ready high).

Reset
REQ-041 rst_i high SHALL asynchronously force IDLE, clear all busy bits, and drive all valids, gnt, trans_req_o and all payload outputs to 0, including mid-transaction (no partial beat is resumed).

Verification
REQ-042 Write at 0x1000_0004, id=5'b00100, wdata=0xDEADBEEF, be=4'hF, readies high -> gnt cycle 0; trans_id=2; cycle 1: aw_addr=0x1000_0004, aw_id=2, w_data=0xDEADBEEF_00000000, w_strb=8'hF0; idle cycle 2.
REQ-043 Read at 0x2000_0000, id=5'b00001, ar_ready low 3 cycles -> ar_valid held 4 cycles with stable addr/id=0; one trans_req_o pulse.
REQ-044 Second request on ID 2 while busy -> gnt=0 until rsp_done_i with rsp_id_i=2, then gnt the following cycle.
REQ-045 Write with aw_ready at cycle 1 and w_ready at cycle 3 -> aw_valid drops after cycle 1, w_valid after cycle 3, IDLE at cycle 4.
REQ-046 rst_i asserted while w_valid is pending -> all outputs 0 immediately; the next request on the same ID is granted.
